spi_flash_erase: RTL and testbench
==================================

SPI_FLASH_ERASE -- requirements
Module: spi_flash_erase

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: sys_clk cycles per SCK half-period (legal range >=1).
REQ-002 SHALL have parameter CS_HOLD, default 4: sys_clk cycles used for cs_n setup, cs_n hold, and the minimum cs_n-high gap.
REQ-003 SHALL have parameter POLL_EN, default 1: 1 = poll the status register after erase; 0 = finish directly after the erase command.
REQ-004 SHALL have parameter POLL_MAX, default 65535: maximum number of RDSR transactions per operation.
REQ-005 sys_clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request; sampled only in IDLE.
REQ-008 mode  in  1  0 = sector erase (0xD8 plus address), 1 = bulk erase (0xC7).
REQ-009 addr  in  24  sector address; ignored for bulk erase.
REQ-010 miso  in  1  serial data from the flash.
REQ-011 busy  out  1  high from start acceptance until done.
REQ-012 done  out  1  one-cycle pulse at the end of an operation.
REQ-013 err  out  1  one-cycle pulse, coincident with done, when POLL_MAX is exhausted.
REQ-014 sck, cs_n, mosi  out  1 each  SPI mode 0 bus; all are registered outputs.

Function
REQ-015 SHALL implement these states: IDLE, WREN, GAP1, ERASE, GAP2, POLL, GAP3, FIN.
- IDLE --start--> WREN --> GAP1 --> ERASE --> GAP2.
- GAP2 --> POLL when POLL_EN=1; GAP2 --> FIN when POLL_EN=0.
- POLL --WIP=0--> FIN.
- POLL --WIP=1 and polls<POLL_MAX--> GAP3 --> POLL.
- POLL --WIP=1 and polls=POLL_MAX--> FIN with err.
- FIN --> IDLE.
REQ-016 SHALL latch mode and addr when start is accepted; later changes to these inputs SHALL NOT affect the operation in progress.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL drive busy=1 and cs_n=0 in the cycle after start is sampled.
REQ-019 Each transaction SHALL follow this sequence:
- cs_n low, sck low, for CS_HOLD cycles;
- N bits, MSB first, each bit = CLK_DIV cycles sck low followed by CLK_DIV cycles sck high;
- CS_HOLD cycles with sck low;
- cs_n high.
REQ-020 cs_n low duration SHALL equal exactly 2*CS_HOLD + 2*CLK_DIV*N cycles.
REQ-021 mosi SHALL change only while sck is low and SHALL be stable throughout each sck-high phase.
REQ-022 miso SHALL be sampled on the sys_clk edge that drives sck from low to high.
REQ-023 Transaction contents:
- WREN: 0x06, N=8.
- ERASE, mode=0: 0xD8 followed by addr[23:0], N=32.
- ERASE, mode=1: 0xC7, N=8.
- POLL: 0x05 followed by 8 read bits, N=16, mosi=0 during the read bits.
REQ-024 WIP SHALL be the last bit received in a POLL transaction (status bit 0).
REQ-025 GAP states SHALL hold cs_n high for exactly CS_HOLD cycles.
REQ-026 The poll counter SHALL be at least 16 bits wide, SHALL clear on start acceptance, and SHALL increment once per POLL transaction; it SHALL NOT wrap.
REQ-027 In FIN, done SHALL pulse for one cycle and busy SHALL fall in the same cycle; a start sampled in that cycle SHALL be ignored.
REQ-028 When the operation ends, sck SHALL idle at 0, mosi SHALL idle at 0, and cs_n SHALL idle at 1.

Reset
REQ-029 While sys_rst=1 the block SHALL drive: state IDLE, sck=0, cs_n=1, mosi=0, busy=0, done=0, err=0, with all counters cleared.
REQ-030 Reset asserted mid-transaction SHALL force cs_n=1 and sck=0 on the next edge; it SHALL emit no done and no err pulse.
REQ-031 The first start after reset deasserts SHALL be accepted normally.

Verification (CLK_DIV=2, CS_HOLD=4 unless stated)
REQ-032 Bulk erase with POLL_EN=0, start with mode=1:
- two cs_n-low windows of 40 cycles each, separated by a 4-cycle gap;
- mosi bytes 0x06, then 0xC7;
- one done pulse, err=0.
REQ-033 Sector erase with addr=0x123456:
- 40-cycle window carrying 0x06;
- 136-cycle window carrying D8 12 34 56;
- addr changed to 0xFFFFFF mid-operation has no effect on the shifted bytes.
REQ-034 Flash model returns status 0x01 for three polls, then 0x00:
- four 72-cycle RDSR windows carrying 0x05;
- then done with err=0.
REQ-035 POLL_MAX=2 with WIP stuck at 1:
- exactly two RDSR windows;
- then done and err pulse in the same cycle.
REQ-036 start pulses during busy and in the done cycle are ignored: exactly one operation runs.
REQ-037 sys_rst pulsed during the ERASE bit phase:
- the next cycle shows cs_n=1, sck=0, mosi=0, busy=0;
- a following start produces a complete, correct sequence.

Source files
------------

// File: rtl/spi_flash_erase.sv
// spi_flash_erase: SPI NOR erase sequencer (WREN, sector/bulk erase, optional RDSR polling)
module spi_flash_erase #(
  parameter int CLK_DIV  = 2,
  parameter int CS_HOLD  = 4,
  parameter int POLL_EN  = 1,
  parameter int POLL_MAX = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        mode,
  input  logic [23:0] addr,
  input  logic        miso,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi
);
  localparam logic [2:0] IDLE = 3'd0, WREN = 3'd1, GAP1 = 3'd2, ERASE = 3'd3,
                         GAP2 = 3'd4, POLL = 3'd5, GAP3 = 3'd6, FIN = 3'd7;
  localparam logic [1:0] SETUP = 2'd0, SHIFT = 2'd1, HOLD = 2'd2;
  logic [2:0]  st, tgt, after;
  logic [1:0]  ph;
  logic [31:0] cnt, sr, ld_sr, polls;
  logic [5:0]  nb, ld_nb;
  logic [7:0]  rx;
  logic        md;
  logic [23:0] ad;
  // tgt: transaction a gap (or IDLE) launches; after: where a finished transaction goes
  always_comb begin
    tgt   = st == IDLE ? WREN : st == GAP1 ? ERASE : POLL;
    ld_sr = tgt == WREN ? {8'h06, 24'h0} : tgt == POLL ? {8'h05, 24'h0} :
            md ? {8'hC7, 24'h0} : {8'hD8, ad};
    ld_nb = tgt == WREN || (tgt == ERASE && md) ? 6'd8 : tgt == POLL ? 6'd16 : 6'd32;
    after = st == WREN ? GAP1 : st == ERASE ? GAP2 :
            rx[0] && polls < POLL_MAX ? GAP3 : FIN;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st    <= IDLE;
      ph    <= SETUP;
      cnt   <= '0;
      sr    <= '0;
      nb    <= '0;
      rx    <= '0;
      polls <= '0;
      md    <= 1'b0;
      ad    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      sck   <= 1'b0;
      cs_n  <= 1'b1;
      mosi  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      cnt  <= cnt + 1;
      case (st)
        IDLE, GAP1, GAP2, GAP3:
          if (st == IDLE ? start : cnt == CS_HOLD - 1) begin
            if (st == GAP2 && POLL_EN == 0) begin
              st   <= FIN;
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              st   <= tgt;
              ph   <= SETUP;
              cnt  <= '0;
              cs_n <= 1'b0;
              sr   <= ld_sr;
              nb   <= ld_nb;
              mosi <= ld_sr[31];
              if (tgt == POLL) polls <= polls + {31'd0, ~&polls};
            end
            if (st == IDLE) begin
              md    <= mode;
              ad    <= addr;
              polls <= '0;
              busy  <= 1'b1;
            end
          end
        FIN: st <= IDLE;
        default:
          if (ph == SETUP) begin
            if (cnt == CS_HOLD - 1) begin
              ph  <= SHIFT;
              cnt <= '0;
            end
          end else if (ph == SHIFT) begin
            if (cnt == CLK_DIV - 1) begin
              sck <= 1'b1;
              rx  <= {rx[6:0], miso};
            end
            // mosi advances only on the edge that returns sck low
            if (cnt == 2 * CLK_DIV - 1) begin
              sck  <= 1'b0;
              cnt  <= '0;
              sr   <= sr << 1;
              mosi <= sr[30];
              nb   <= nb - 6'd1;
              if (nb == 6'd1) ph <= HOLD;
            end
          end else if (cnt == CS_HOLD - 1) begin
            st   <= after;
            cs_n <= 1'b1;
            cnt  <= '0;
            if (after == FIN) begin
              done <= 1'b1;
              err  <= rx[0];
              busy <= 1'b0;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_erase.sv
// tb_spi_flash_erase: scoreboard bench over three parameterisations sharing one bus monitor
module tb_spi_flash_erase;
  typedef struct {int len; int nbits; logic [31:0] data; int gap;} win_t;
  logic sys_clk = 0, sys_rst = 1, start = 0, mode = 0, miso;
  logic [23:0] addr = '0;
  logic [1:0] sel = '0;
  logic [2:0] cs_v, sck_v, mosi_v, busy_v, done_v, err_v;
  logic cs_m, sck_m, mosi_m, busy_m, done_m, err_m;
  int n_cmp = 0, n_bad = 0, wip_n = 0, aborts = 0;
  win_t exp_q[$];
  logic err_q[$];
  always #5 sys_clk = ~sys_clk;

  spi_flash_erase #(.POLL_EN(0)) d0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .start(start && sel == 2'd0),
    .mode(mode), .addr(addr), .miso(miso), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .sck(sck_v[0]), .cs_n(cs_v[0]), .mosi(mosi_v[0]));
  spi_flash_erase #(.POLL_EN(1)) d1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .start(start && sel == 2'd1),
    .mode(mode), .addr(addr), .miso(miso), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .sck(sck_v[1]), .cs_n(cs_v[1]), .mosi(mosi_v[1]));
  spi_flash_erase #(.POLL_EN(1), .POLL_MAX(2)) d2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .start(start && sel == 2'd2),
    .mode(mode), .addr(addr), .miso(miso), .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]),
    .sck(sck_v[2]), .cs_n(cs_v[2]), .mosi(mosi_v[2]));

  assign cs_m   = cs_v[sel];
  assign sck_m  = sck_v[sel];
  assign mosi_m = mosi_v[sel];
  assign busy_m = busy_v[sel];
  assign done_m = done_v[sel];
  assign err_m  = err_v[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus monitor + flash model: status WIP=1 for the first wip_n polls of an operation
  logic pc = 1, ps = 0, pm = 0, glitch = 0;
  logic [31:0] sh = '0;
  int len = 0, hi = 0, gap = 0, nrise = 0, nwin = 0, ndone = 0, poll_idx = 0, aborts_seen = 0;
  win_t e;
  assign miso = !cs_m && nrise == 15 && poll_idx < wip_n;
  always @(negedge sys_clk) begin
    if (!cs_m) begin
      if (pc) begin
        gap = hi; len = 0; sh = '0; nrise = 0; glitch = 0;
      end
      len++;
      if (sck_m && !ps) begin
        sh = {sh[30:0], mosi_m};
        nrise++;
      end
      if (sck_m && ps && mosi_m != pm) glitch = 1;
    end else begin
      if (!pc) begin
        nwin++;
        if (aborts > aborts_seen) aborts_seen++;
        else if (exp_q.size() == 0) check("extra_win", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("win_len", len, e.len);
          check("win_bits", nrise, e.nbits);
          check("win_data", sh, e.data);
          if (e.gap >= 0) check("cs_gap", gap, e.gap);
          check("mosi_stable", {31'd0, glitch}, 0);
        end
        if (nrise == 8 && sh == 32'h06) poll_idx = 0;
        if (nrise == 16 && sh[15:8] == 8'h05) poll_idx++;
      end
      hi = pc ? hi + 1 : 1;
    end
    if (done_m) begin
      ndone++;
      check("win_left", exp_q.size(), 0);
      check("busy_at_done", {31'd0, busy_m}, 0);
      if (err_q.size() == 0) check("extra_done", 1, 0);
      else check("err", {31'd0, err_m}, {31'd0, err_q.pop_front()});
    end else if (err_m) check("err_alone", 1, 0);
    pc = cs_m; ps = sck_m; pm = mosi_m;
  end

  task automatic push_op(input logic m, input logic [23:0] a, input int np, input logic er);
    exp_q.push_back('{40, 8, 32'h06, -1});
    exp_q.push_back(m ? '{40, 8, 32'hC7, 4} : '{136, 32, {8'hD8, a}, 4});
    for (int i = 0; i < np; i++) exp_q.push_back('{72, 16, 32'h0500, 4});
    err_q.push_back(er);
  endtask

  task automatic go(input logic m, input logic [23:0] a);
    @(negedge sys_clk);
    start = 1; mode = m; addr = a;
    @(negedge sys_clk);
    start = 0;
    check("busy_after_start", {31'd0, busy_m}, 1);
    check("cs_after_start", {31'd0, cs_m}, 0);
  endtask

  task automatic wait_done(input bit poke);
    int t = 0;
    while (!done_m && t < 20000) begin
      @(negedge sys_clk);
      t++;
    end
    check("done_seen", {31'd0, t < 20000}, 1);
    if (poke) start = 1;
    @(negedge sys_clk);
    start = 0;
    check("idle_cs", {31'd0, cs_m}, 1);
    check("idle_sck", {31'd0, sck_m}, 0);
    check("idle_mosi", {31'd0, mosi_m}, 0);
    check("idle_busy", {31'd0, busy_m}, 0);
    check("done_one_cycle", {31'd0, done_m}, 0);
  endtask

  initial begin
    int d, n0, t;
    repeat (3) @(negedge sys_clk);
    check("rst_cs", {31'd0, cs_m}, 1);
    check("rst_sck", {31'd0, sck_m}, 0);
    check("rst_mosi", {31'd0, mosi_m}, 0);
    check("rst_busy", {31'd0, busy_m}, 0);
    check("rst_done", {31'd0, done_m}, 0);
    check("rst_err", {31'd0, err_m}, 0);
    sys_rst = 0;
    // bulk erase, no polling
    push_op(1, 24'h0, 0, 0);
    go(1, 24'h0);
    wait_done(0);
    // sector erase; inputs scrambled mid-operation
    push_op(0, 24'h123456, 0, 0);
    go(0, 24'h123456);
    repeat (20) @(negedge sys_clk);
    addr = 24'hFFFFFF; mode = 1;
    wait_done(0);
    // three busy polls then ready
    sel = 2'd1; wip_n = 3;
    push_op(1, 24'h0, 4, 0);
    go(1, 24'h0);
    wait_done(0);
    // WIP stuck, POLL_MAX=2
    sel = 2'd2; wip_n = 1000;
    push_op(0, 24'hABCDEF, 2, 1);
    go(0, 24'hABCDEF);
    wait_done(0);
    // starts while busy and in the done cycle are ignored
    sel = 2'd0; wip_n = 0; d = ndone;
    push_op(1, 24'h0, 0, 0);
    go(1, 24'h0);
    for (int i = 0; i < 5; i++) begin
      repeat (7) @(negedge sys_clk);
      start = 1; mode = 0; addr = 24'h111111;
      @(negedge sys_clk);
      start = 0;
    end
    wait_done(1);
    repeat (150) @(negedge sys_clk);
    check("one_op", ndone - d, 1);
    // reset during the erase bit phase
    exp_q.push_back('{40, 8, 32'h06, -1});
    n0 = nwin; d = ndone;
    go(0, 24'h654321);
    t = 0;
    do begin
      @(negedge sys_clk);
      #1 t++;
    end while (!(nwin > n0 && !cs_m && nrise >= 5) && t < 5000);
    check("erase_reached", {31'd0, t < 5000}, 1);
    aborts++;
    sys_rst = 1;
    @(negedge sys_clk);
    check("mid_rst_cs", {31'd0, cs_m}, 1);
    check("mid_rst_sck", {31'd0, sck_m}, 0);
    check("mid_rst_mosi", {31'd0, mosi_m}, 0);
    check("mid_rst_busy", {31'd0, busy_m}, 0);
    sys_rst = 0;
    repeat (10) @(negedge sys_clk);
    check("no_done_on_rst", ndone - d, 0);
    push_op(0, 24'h654321, 0, 0);
    go(0, 24'h654321);
    wait_done(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
